// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline stage: control + data bundle behind a valid/ready handshake, optional 2-entry skid.
// Latency: 1 cycle from accept to out_*; full-rate streaming with no throughput loss.
// Backpressure: SKID=1 registers in_ready (drops once the skid entry fills); SKID=0 in_ready = !M | out_ready.
//
// Ports:
//   clk, rst_              clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready      upstream handshake; in_ctrl/in_data carry the word
//   flush                  synchronous kill of held and incoming words
//   out_valid/out_ready    downstream handshake; out_ctrl/out_data always sourced from main entry M
//   stall_cnt/bubble_cnt   saturating performance counters
module pipe_elastic_stage #(
    parameter int                  DATA_BITS   = 64,
    parameter int                  CTRL_BITS   = 8,
    parameter logic [CTRL_BITS-1:0] CTRL_BUBBLE = 8'h1C,
    parameter int                  SKID        = 1,
    parameter int                  CNT_BITS    = 16
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CTRL_BITS-1:0] in_ctrl,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTRL_BITS-1:0] out_ctrl,
    output logic [DATA_BITS-1:0] out_data,
    output logic [CNT_BITS-1:0]  stall_cnt,
    output logic [CNT_BITS-1:0]  bubble_cnt
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    // Main entry M: the only source of out_*.
    logic                 r_m_vld;
    logic [CTRL_BITS-1:0] r_m_ctrl;
    logic [DATA_BITS-1:0] r_m_dat;

    // Skid entry S as seen by M's refill mux (tied off when SKID=0).
    logic                 w_s_vld;
    logic [CTRL_BITS-1:0] w_s_ctrl;
    logic [DATA_BITS-1:0] w_s_dat;

    logic w_accept;
    logic w_m_free;

    logic [CNT_BITS-1:0] r_stall_cnt;
    logic [CNT_BITS-1:0] r_bubble_cnt;

    assign w_accept = in_valid & in_ready;
    // M can take a new word when it is empty or its current word leaves this cycle.
    assign w_m_free = !r_m_vld | out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic                 r_s_vld;
            logic [CTRL_BITS-1:0] r_s_ctrl;
            logic [DATA_BITS-1:0] r_s_dat;

            // Registered ready: depends only on S occupancy, never on out_ready.
            assign in_ready = !r_s_vld;

            always_ff @(posedge clk or negedge rst_) begin
                if (!rst_) begin
                    r_s_vld  <= 1'b0;
                    r_s_ctrl <= CTRL_BUBBLE;
                    r_s_dat  <= '0;
                end else if (flush) begin
                    r_s_vld  <= 1'b0;
                end else if (w_m_free) begin
                    // S (if valid) moves into M; no accept can coincide because in_ready=!S.
                    r_s_vld  <= 1'b0;
                end else if (w_accept) begin
                    // M is stuck: park the incoming word behind it.
                    r_s_vld  <= 1'b1;
                    r_s_ctrl <= in_ctrl;
                    r_s_dat  <= in_data;
                end
            end

            assign w_s_vld  = r_s_vld;
            assign w_s_ctrl = r_s_ctrl;
            assign w_s_dat  = r_s_dat;
        end else begin : g_no_skid
            assign in_ready = !r_m_vld | out_ready;
            assign w_s_vld  = 1'b0;
            assign w_s_ctrl = CTRL_BUBBLE;
            assign w_s_dat  = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_m_vld  <= 1'b0;
            r_m_ctrl <= CTRL_BUBBLE;
            r_m_dat  <= '0;
        end else if (flush) begin
            // Data is left in place; out_ctrl is masked by r_m_vld instead.
            r_m_vld  <= 1'b0;
        end else if (w_m_free) begin
            if (w_s_vld) begin
                // Oldest word first: S precedes anything accepted now.
                r_m_vld  <= 1'b1;
                r_m_ctrl <= w_s_ctrl;
                r_m_dat  <= w_s_dat;
            end else if (w_accept) begin
                r_m_vld  <= 1'b1;
                r_m_ctrl <= in_ctrl;
                r_m_dat  <= in_data;
            end else begin
                r_m_vld  <= 1'b0;
            end
        end
    end

    // Saturating counters; flush leaves them alone, only reset clears them.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_m_vld && !out_ready && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (!r_m_vld && out_ready && (r_bubble_cnt != CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign out_valid  = r_m_vld;
    // ctrl is only ever loaded from accepted words, so the mask keeps it defined.
    assign out_ctrl   = r_m_vld ? r_m_ctrl : CTRL_BUBBLE;
    assign out_data   = r_m_dat;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Bench for pipe_elastic_stage: a SKID=1/CNT_BITS=4 instance and a SKID=0/CNT_BITS=16 instance
// share one stimulus stream; each is checked every cycle against a FIFO-occupancy model,
// plus directed scenarios with literal expectations.
module tb_pipe_elastic_stage;

    localparam logic [7:0] BUB = 8'h1C;

    logic        clk = 1'b0;
    logic        rst_;
    logic        in_valid;
    logic [7:0]  in_ctrl;
    logic [63:0] in_data;
    logic        flush;
    logic        out_ready;

    logic        a_in_ready, a_out_valid;
    logic [7:0]  a_out_ctrl;
    logic [63:0] a_out_data;
    logic [3:0]  a_stall_cnt, a_bubble_cnt;

    logic        b_in_ready, b_out_valid;
    logic [7:0]  b_out_ctrl;
    logic [63:0] b_out_data;
    logic [15:0] b_stall_cnt, b_bubble_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_elastic_stage #(.DATA_BITS(64), .CTRL_BITS(8), .CTRL_BUBBLE(8'h1C), .SKID(1), .CNT_BITS(4)) u_a (
        .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl),
        .in_data(in_data), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_ctrl(a_out_ctrl), .out_data(a_out_data), .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt)
    );

    pipe_elastic_stage #(.DATA_BITS(64), .CTRL_BITS(8), .CTRL_BUBBLE(8'h1C), .SKID(0), .CNT_BITS(16)) u_b (
        .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl),
        .in_data(in_data), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_ctrl(b_out_ctrl), .out_data(b_out_data), .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    // Model: each stage is a FIFO of capacity 2 (k=0, skid) or 1 (k=1, no skid).
    int          cnt [2];
    logic [7:0]  mc  [2][2];
    logic [63:0] md  [2][2];
    logic [63:0] last[2];
    int          st  [2];
    int          bu  [2];
    logic [63:0] log_q[$];   // words delivered by the skid instance

    task automatic model_cycle(input int k, input logic av, input logic ar, input logic [7:0] ac,
                               input logic [63:0] ad, input logic [15:0] ast, input logic [15:0] abu);
        string pf;
        int    mx;
        logic  ev, erdy, acc, drn;
        logic [7:0]  ec;
        logic [63:0] ed;
        pf   = (k == 0) ? "skid" : "noskid";
        mx   = (k == 0) ? 15 : 65535;
        if (!rst_) begin
            cnt[k] = 0; last[k] = 64'd0; st[k] = 0; bu[k] = 0;
        end
        ev   = (cnt[k] > 0);
        ec   = ev ? mc[k][0] : BUB;
        ed   = ev ? md[k][0] : last[k];
        erdy = (k == 0) ? (cnt[k] < 2) : ((cnt[k] == 0) || out_ready);
        chk({pf, "_out_valid"}, {63'd0, av}, {63'd0, ev});
        chk({pf, "_in_ready"},  {63'd0, ar}, {63'd0, erdy});
        chk({pf, "_out_ctrl"},  {56'd0, ac}, {56'd0, ec});
        chk({pf, "_out_data"},  ad, ed);
        chk({pf, "_stall_cnt"}, {48'd0, ast}, 64'(st[k]));
        chk({pf, "_bubble_cnt"}, {48'd0, abu}, 64'(bu[k]));
        if (rst_) begin
            acc = in_valid && erdy;
            drn = ev && out_ready;
            if (ev && !out_ready && st[k] < mx) st[k]++;
            if (!ev && out_ready && bu[k] < mx) bu[k]++;
            if (drn && k == 0) log_q.push_back(md[k][0]);
            if (flush) begin
                cnt[k] = 0;
            end else begin
                if (drn) begin
                    mc[k][0] = mc[k][1]; md[k][0] = md[k][1]; cnt[k]--;
                end
                if (acc) begin
                    mc[k][cnt[k]] = in_ctrl; md[k][cnt[k]] = in_data; cnt[k]++;
                end
            end
            if (cnt[k] > 0) last[k] = md[k][0];
        end
    endtask

    // Compare process: outputs checked once per cycle, then model advanced to the next edge.
    always @(negedge clk) begin
        model_cycle(0, a_out_valid, a_in_ready, a_out_ctrl, a_out_data, {12'd0, a_stall_cnt}, {12'd0, a_bubble_cnt});
        model_cycle(1, b_out_valid, b_in_ready, b_out_ctrl, b_out_data, b_stall_cnt, b_bubble_cnt);
    end

    task automatic step_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        step_drive();
        rst_ = 1'b0;
        step_drive();
        rst_ = 1'b1;
    endtask

    initial begin
        int idx;
        rst_ = 1'b0; in_valid = 1'b0; in_ctrl = 8'h00; in_data = 64'd0; flush = 1'b0; out_ready = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 5; i++) begin
            step_drive();
            in_valid = 1'($urandom); in_ctrl = 8'($urandom); in_data = {$urandom, $urandom};
            flush = 1'($urandom); out_ready = 1'($urandom);
        end
        @(negedge clk);
        chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("rst_out_ctrl", {56'd0, a_out_ctrl}, 64'h1C);
        chk("rst_out_data", a_out_data, 64'd0);
        chk("rst_in_ready", {63'd0, a_in_ready}, 64'd1);
        chk("rst_counters", {a_stall_cnt, a_bubble_cnt}, 64'd0);
        step_drive();
        rst_ = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;

        // Streaming 1..8 at full rate.
        log_q.delete();
        for (int i = 1; i <= 8; i++) begin
            step_drive();
            in_valid = 1'b1; in_data = 64'(i); in_ctrl = 8'(i);
            @(negedge clk);
            chk("stream_in_ready", {63'd0, a_in_ready}, 64'd1);
            if (i > 1) chk("stream_latency", a_out_data, 64'(i - 1));
        end
        step_drive();
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_last", a_out_data, 64'd8);
        step_drive();
        @(negedge clk);
        chk("stream_count", 64'(log_q.size()), 64'd8);
        for (int i = 0; i < log_q.size(); i++) chk("stream_order", log_q[i], 64'(i + 1));
        chk("stream_stall", {60'd0, a_stall_cnt}, 64'd0);

        // Backpressure: out_ready low for cycles 2..4 of the burst.
        reset_pulse();
        log_q.delete();
        idx = 1;
        for (int c = 0; c < 20; c++) begin
            step_drive();
            in_valid = (idx <= 4); in_data = 64'(idx); in_ctrl = 8'(idx);
            out_ready = !(c >= 2 && c <= 4);
            @(negedge clk);
            if (c == 3) begin
                chk("bp_in_ready_low", {63'd0, a_in_ready}, 64'd0);
                chk("bp_m_holds_2", a_out_data, 64'd2);
            end
            if (in_valid && a_in_ready) idx++;
            if (idx > 4 && c >= 8) break;
        end
        chk("bp_all_sent", 64'(idx), 64'd5);
        chk("bp_stall_cnt", {60'd0, a_stall_cnt}, 64'd3);
        chk("bp_count", 64'(log_q.size()), 64'd4);
        for (int i = 0; i < log_q.size(); i++) chk("bp_order", log_q[i], 64'(i + 1));

        // Flush with M=5, S=6 and 7 offered in the flush cycle.
        step_drive();
        in_valid = 1'b0; out_ready = 1'b1;
        step_drive();
        log_q.delete();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd5; in_ctrl = 8'h05;
        step_drive();
        in_data = 64'd6; in_ctrl = 8'h06;
        step_drive();
        in_data = 64'd7; in_ctrl = 8'h07; flush = 1'b1;
        @(negedge clk);
        chk("fl_pre_ctrl", {56'd0, a_out_ctrl}, 64'h05);
        chk("fl_pre_ready", {63'd0, a_in_ready}, 64'd0);
        step_drive();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("fl_out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("fl_out_ctrl", {56'd0, a_out_ctrl}, 64'h1C);
        chk("fl_in_ready", {63'd0, a_in_ready}, 64'd1);
        repeat (3) step_drive();
        chk("fl_nothing_emitted", 64'(log_q.size()), 64'd0);

        // Bubble counter saturation.
        reset_pulse();
        out_ready = 1'b1; in_valid = 1'b0;
        repeat (15) step_drive();
        chk("bub_reach_15", {60'd0, a_bubble_cnt}, 64'd15);
        repeat (5) step_drive();
        chk("bub_stay_15", {60'd0, a_bubble_cnt}, 64'd15);
        chk("bub_wide_20", {48'd0, b_bubble_cnt}, 64'd20);

        // SKID=0: combinational in_ready.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd9; in_ctrl = 8'h09;
        @(negedge clk);
        chk("s0_empty_ready", {63'd0, b_in_ready}, 64'd1);
        step_drive();
        in_data = 64'd10; in_ctrl = 8'h0A;
        @(negedge clk);
        chk("s0_full_not_ready", {63'd0, b_in_ready}, 64'd0);
        chk("s0_holds_9", b_out_data, 64'd9);
        step_drive();
        out_ready = 1'b1;
        @(negedge clk);
        chk("s0_ready_same_cycle", {63'd0, b_in_ready}, 64'd1);
        for (int d = 11; d <= 13; d++) begin
            step_drive();
            in_data = 64'(d); in_ctrl = 8'(d);
            @(negedge clk);
            chk("s0_rate_ready", {63'd0, b_in_ready}, 64'd1);
            chk("s0_rate_data", b_out_data, 64'(d - 1));
        end
        step_drive();
        in_valid = 1'b0;

        // Random traffic; rare resets exercise async reset mid-operation.
        for (int i = 0; i < 3000; i++) begin
            step_drive();
            rst_      = ($urandom_range(0, 249) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = (i % 600 < 300) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            in_ctrl   = 8'($urandom);
            in_data   = {$urandom, $urandom};
        end
        step_drive();
        rst_ = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step_drive();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
